ex_iter: RTL and testbench

Parametrised, registered execute stage for the THCO-MIPS pipeline; it replaces the purely combinational EX block. It sits between ID/EX and EX/MEM with valid/ready handshakes on both sides. It adds iterative multiply and divide, which stall the upstream stage while they run, and it can be flushed. All results are held in an output register, so EX/MEM sees stable data while MEM stalls.

---
 rtl/ex_iter_pkg.sv | 28 ++
 rtl/ex_iter_md.sv | 85 ++++++++
 rtl/ex_iter.sv | 193 +++++++++++++++++++
 tb/tb_ex_iter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_iter_pkg.sv
// Shared opcode, state and type definitions for the ex_iter execute stage.
// The DIV opcode only executes when EX_DIV_EN is defined.
package ex_iter_pkg;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t ALU_NOP = 4'd0;
  localparam alu_op_t ALU_ADD = 4'd1;
  localparam alu_op_t ALU_SUB = 4'd2;
  localparam alu_op_t ALU_AND = 4'd3;
  localparam alu_op_t ALU_OR  = 4'd4;
  localparam alu_op_t ALU_NOT = 4'd5;
  localparam alu_op_t ALU_SLL = 4'd6;
  localparam alu_op_t ALU_SRA = 4'd7;
  localparam alu_op_t ALU_CMP = 4'd8;
  localparam alu_op_t ALU_SLT = 4'd9;
  localparam alu_op_t ALU_SW  = 4'd10;
  localparam alu_op_t ALU_LW  = 4'd11;
  localparam alu_op_t ALU_MUL = 4'd12;
  localparam alu_op_t ALU_DIV = 4'd13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    HOLD = 2'd2
  } ex_state_e;

endpackage

// File: rtl/ex_iter_md.sv
// Iterative one-bit-per-cycle shift-add multiplier and restoring divider.
// The divider is built only when EX_DIV_EN is defined.
module ex_iter_md
  import ex_iter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             en,
`ifdef EX_DIV_EN
  input  logic             is_div,
`endif
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q;
  logic [WIDTH-1:0] a_n, b_n, acc_n;
`ifdef EX_DIV_EN
  logic             div_q;
  logic [WIDTH:0]   shifted;
`endif

  // Mul: a = shifted multiplicand, b = multiplier, acc = partial product.
  // Div: a = dividend shifting into quotient, b = divisor, acc = remainder.
  always_comb begin
    a_n   = {a_q[WIDTH-2:0], 1'b0};
    b_n   = b_q >> 1;
    acc_n = b_q[0] ? acc_q + a_q : acc_q;
`ifdef EX_DIV_EN
    shifted = {acc_q, a_q[WIDTH-1]};
    if (div_q) begin
      b_n = b_q;
      if (shifted >= {1'b0, b_q}) begin
        acc_n = shifted[WIDTH-1:0] - b_q;
        a_n   = {a_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_n = shifted[WIDTH-1:0];
        a_n   = {a_q[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

  assign done = en && (cnt_q == CW'(WIDTH - 1));

`ifdef EX_DIV_EN
  assign result = done ? (div_q ? a_n : acc_n) : (div_q ? a_q : acc_q);
`else
  assign result = done ? acc_n : acc_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (start) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      a_q   <= op_a;
      b_q   <= op_b;
      acc_q <= '0;
`ifdef EX_DIV_EN
      div_q <= is_div;
`endif
    end else if (en) begin
      a_q   <= a_n;
      b_q   <= b_n;
      acc_q <= acc_n;
    end
  end

endmodule

// File: rtl/ex_iter.sv
// Registered THCO-MIPS execute stage with handshakes, iterative MUL/DIV and flush.
// Define EX_DIV_EN to build the DIV opcode; otherwise DIV behaves as undefined.
module ex_iter
  import ex_iter_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int REGADDR_W = 3,
  parameter int ALUOP_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [ALUOP_W-1:0]   aluOp_i,
  input  logic [WIDTH-1:0]     operand1_i,
  input  logic [WIDTH-1:0]     operand2_i,
  input  logic                 wReg_i,
  input  logic [REGADDR_W-1:0] wRegAddr_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [ALUOP_W-1:0]   aluOp_o,
  output logic [WIDTH-1:0]     memAddr_o,
  output logic                 rMem_o,
  output logic                 wMem_o,
  output logic [WIDTH-1:0]     wData_o,
  output logic                 wReg_o,
  output logic [REGADDR_W-1:0] wRegAddr_o,
  output logic                 busy_o
);

  localparam int CW  = $clog2(WIDTH);
  localparam int SHW = CW - 1;

  // A zero shift field selects a half-width shift.
  function automatic logic [CW-1:0] shift_amt(input logic [SHW-1:0] field);
    return (field == '0) ? CW'(WIDTH / 2) : CW'(field);
  endfunction

  ex_state_e state_q, state_n;

  logic                 can_load, accept, is_iter_op, md_start, md_en, md_done;
  logic                 load_single, load_iter;
  logic [WIDTH-1:0]     md_result;
  logic signed [WIDTH-1:0] op1_s, op2_s;
  logic [CW-1:0]        shamt;
  logic [WIDTH-1:0]     alu_data, alu_addr;
  logic                 alu_rmem, alu_wmem;
  logic [ALUOP_W-1:0]   op_p0;
  logic                 wreg_p0;
  logic [REGADDR_W-1:0] waddr_p0;

  assign op1_s = operand1_i;
  assign op2_s = operand2_i;
  assign shamt = shift_amt(operand2_i[SHW-1:0]);

  assign can_load = !valid_o || ready_i;
  assign ready_o  = !rst && (state_q == IDLE) && can_load && !flush_i;
  assign accept   = valid_i && ready_o;
  assign busy_o   = (state_q != IDLE);

`ifdef EX_DIV_EN
  assign is_iter_op = (aluOp_i == ALUOP_W'(ALU_MUL)) || (aluOp_i == ALUOP_W'(ALU_DIV));
`else
  assign is_iter_op = (aluOp_i == ALUOP_W'(ALU_MUL));
`endif

  assign md_start    = accept && is_iter_op;
  assign load_single = accept && !is_iter_op;
  assign md_en       = (state_q == ITER) && !flush_i;

  always_comb begin
    alu_data = '0;
    alu_addr = '0;
    alu_rmem = 1'b0;
    alu_wmem = 1'b0;
    case (aluOp_i)
      ALUOP_W'(ALU_ADD): alu_data = operand1_i + operand2_i;
      ALUOP_W'(ALU_SUB): alu_data = operand1_i - operand2_i;
      ALUOP_W'(ALU_AND): alu_data = operand1_i & operand2_i;
      ALUOP_W'(ALU_OR):  alu_data = operand1_i | operand2_i;
      ALUOP_W'(ALU_NOT): alu_data = ~operand1_i;
      ALUOP_W'(ALU_SLL): alu_data = operand1_i << shamt;
      ALUOP_W'(ALU_SRA): alu_data = op1_s >>> shamt;
      ALUOP_W'(ALU_CMP): alu_data = (operand1_i == operand2_i) ? '0 : WIDTH'(1);
      ALUOP_W'(ALU_SLT): alu_data = {{(WIDTH-1){1'b0}}, (op1_s < op2_s)};
      ALUOP_W'(ALU_LW): begin
        alu_addr = operand1_i + operand2_i;
        alu_rmem = 1'b1;
      end
      ALUOP_W'(ALU_SW): begin
        alu_addr = operand1_i;
        alu_data = operand2_i;
        alu_wmem = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_n   = state_q;
    load_iter = 1'b0;
    if (flush_i) begin
      state_n = IDLE;
    end else begin
      case (state_q)
        IDLE: if (md_start) state_n = ITER;
        ITER: begin
          if (md_done) begin
            if (can_load) begin
              load_iter = 1'b1;
              state_n   = IDLE;
            end else begin
              state_n = HOLD;
            end
          end
        end
        HOLD: begin
          if (can_load) begin
            load_iter = 1'b1;
            state_n   = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  ex_iter_md #(.WIDTH(WIDTH)) u_md (
    .clk    (clk),
    .rst    (rst),
    .start  (md_start),
    .en     (md_en),
`ifdef EX_DIV_EN
    .is_div (aluOp_i == ALUOP_W'(ALU_DIV)),
`endif
    .op_a   (operand1_i),
    .op_b   (operand2_i),
    .done   (md_done),
    .result (md_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      valid_o <= 1'b0;
    end else begin
      state_q <= state_n;
      if (flush_i)                       valid_o <= 1'b0;
      else if (load_single || load_iter) valid_o <= 1'b1;
      else if (ready_i)                  valid_o <= 1'b0;
    end
  end

  // Stage p0: metadata of an in-flight iterative op, parked until its result loads
  always_ff @(posedge clk) begin
    if (md_start) begin
      op_p0    <= aluOp_i;
      wreg_p0  <= wReg_i;
      waddr_p0 <= wRegAddr_i;
    end
  end

  // Stage p1: output register seen by EX/MEM
  always_ff @(posedge clk) begin
    if (rst) begin
      aluOp_o    <= ALUOP_W'(ALU_NOP);
      wReg_o     <= 1'b0;
      wRegAddr_o <= '0;
      wData_o    <= '0;
      memAddr_o  <= '0;
      rMem_o     <= 1'b0;
      wMem_o     <= 1'b0;
    end else if (load_single) begin
      aluOp_o    <= aluOp_i;
      wReg_o     <= wReg_i;
      wRegAddr_o <= wRegAddr_i;
      wData_o    <= alu_data;
      memAddr_o  <= alu_addr;
      rMem_o     <= alu_rmem;
      wMem_o     <= alu_wmem;
    end else if (load_iter) begin
      aluOp_o    <= op_p0;
      wReg_o     <= wreg_p0;
      wRegAddr_o <= waddr_p0;
      wData_o    <= md_result;
      memAddr_o  <= '0;
      rMem_o     <= 1'b0;
      wMem_o     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_iter.sv
// Self-checking bench for ex_iter: vector table, stall/flush/reset sequences,
// and randomized ops checked against an arithmetic reference model.
module tb_ex_iter;
  import ex_iter_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush_i, valid_i, ready_i, wReg_i;
  logic [3:0]  aluOp_i;
  logic [15:0] operand1_i, operand2_i;
  logic [2:0]  wRegAddr_i;
  logic        ready_o, valid_o, rMem_o, wMem_o, wReg_o, busy_o;
  logic [3:0]  aluOp_o;
  logic [15:0] memAddr_o, wData_o;
  logic [2:0]  wRegAddr_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ex_iter dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .aluOp_i(aluOp_i), .operand1_i(operand1_i), .operand2_i(operand2_i),
    .wReg_i(wReg_i), .wRegAddr_i(wRegAddr_i), .valid_o(valid_o), .ready_i(ready_i),
    .aluOp_o(aluOp_o), .memAddr_o(memAddr_o), .rMem_o(rMem_o), .wMem_o(wMem_o),
    .wData_o(wData_o), .wReg_o(wReg_o), .wRegAddr_o(wRegAddr_o), .busy_o(busy_o)
  );

  typedef struct {
    alu_op_t     op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_d;
    logic        chk_d;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference model straight from the opcode definitions.
  function automatic logic [15:0] ref_data(input alu_op_t op, input logic [15:0] a, input logic [15:0] b);
    int sh;
    longint p;
    logic signed [15:0] sa;
    sh = int'(b % 16'd8);
    if (sh == 0) sh = 8;
    sa = a;
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_NOT: return ~a;
      ALU_SLL: return a << sh;
      ALU_SRA: return 16'(sa >>> sh);
      ALU_CMP: return (a == b) ? 16'd0 : 16'd1;
      ALU_SLT: return ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
      ALU_SW:  return b;
      ALU_MUL: begin
        p = longint'(a) * longint'(b);
        return p[15:0];
      end
`ifdef EX_DIV_EN
      ALU_DIV: return (b == 16'd0) ? 16'hFFFF : a / b;
`endif
      default: return 16'd0;
    endcase
  endfunction

  function automatic logic [15:0] ref_addr(input alu_op_t op, input logic [15:0] a, input logic [15:0] b);
    if (op == ALU_LW) return a + b;
    if (op == ALU_SW) return a;
    return 16'd0;
  endfunction

  task automatic check_single(input string tag, input alu_op_t op, input logic [15:0] a,
                              input logic [15:0] b, input logic [15:0] exp_d, input logic chk_d);
    check({tag, " valid"}, valid_o, 1);
    if (chk_d) check({tag, " data"}, wData_o, exp_d);
    if (op == ALU_LW || op == ALU_SW) check({tag, " addr"}, memAddr_o, ref_addr(op, a, b));
    check({tag, " strobes"}, {rMem_o, wMem_o}, {op == ALU_LW, op == ALU_SW});
    check({tag, " aluOp_o"}, aluOp_o, op);
  endtask

  // Issue an iterative op and follow it to completion; optionally stall MEM.
  task automatic run_iter(input string tag, input alu_op_t op, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] exp_d, input logic stall);
    int lat;
    logic bad;
    logic [15:0] held;
    aluOp_i = op; operand1_i = a; operand2_i = b;
    wReg_i = 1'b1; wRegAddr_i = 3'd5; valid_i = 1'b1; ready_i = 1'b1;
    cycle();
    valid_i = 1'b0; aluOp_i = ALU_NOP; wRegAddr_i = 3'd0; wReg_i = 1'b0;
    ready_i = !stall;
    lat = 0;
    bad = 1'b0;
    while (!valid_o && lat < 40) begin
      if (!busy_o || ready_o) bad = 1'b1;
      cycle();
      lat++;
    end
    check({tag, " latency"}, lat, 16);
    check({tag, " busy/ready while iterating"}, bad, 0);
    check({tag, " data"}, wData_o, exp_d);
    check({tag, " meta"}, {aluOp_o, wReg_o, wRegAddr_o}, {op, 1'b1, 3'd5});
    check({tag, " busy after"}, busy_o, 0);
    if (stall) begin
      held = wData_o;
      bad = 1'b0;
      repeat (3) begin
        cycle();
        if (!valid_o || wData_o !== held || ready_o) bad = 1'b1;
      end
      check({tag, " stalled output stable"}, bad, 0);
      ready_i = 1'b1;
    end
    cycle();
    check({tag, " drained"}, valid_o, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    alu_op_t single_ops[12];
    logic bad;
    alu_op_t op;
    logic [15:0] a, b;

    vecs.push_back('{ALU_ADD, 16'h7FFF, 16'h0001, 16'h8000, 1'b1});
    vecs.push_back('{ALU_SUB, 16'h0000, 16'h0001, 16'hFFFF, 1'b1});
    vecs.push_back('{ALU_SLT, 16'hFFFF, 16'h0001, 16'h0001, 1'b1});
    vecs.push_back('{ALU_SLT, 16'h0001, 16'hFFFF, 16'h0000, 1'b1});
    vecs.push_back('{ALU_SRA, 16'h8000, 16'h0000, 16'hFF80, 1'b1});
    vecs.push_back('{ALU_SLL, 16'h0001, 16'h0003, 16'h0008, 1'b1});
    vecs.push_back('{ALU_SRA, 16'h8000, 16'h0001, 16'hC000, 1'b1});
    vecs.push_back('{ALU_SLL, 16'h00FF, 16'h0018, 16'hFF00, 1'b1});
    vecs.push_back('{ALU_CMP, 16'h1234, 16'h1234, 16'h0000, 1'b1});
    vecs.push_back('{ALU_CMP, 16'h1234, 16'h1235, 16'h0001, 1'b1});
    vecs.push_back('{ALU_AND, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b1});
    vecs.push_back('{ALU_OR,  16'hF0F0, 16'h0F00, 16'hFFF0, 1'b1});
    vecs.push_back('{ALU_NOT, 16'h00FF, 16'h1234, 16'hFF00, 1'b1});
    vecs.push_back('{ALU_LW,  16'h1000, 16'h0004, 16'h0000, 1'b0});
    vecs.push_back('{ALU_SW,  16'h2000, 16'hBEEF, 16'hBEEF, 1'b1});
    vecs.push_back('{ALU_NOP, 16'h1111, 16'h2222, 16'h0000, 1'b1});
    vecs.push_back('{alu_op_t'(4'd15), 16'h1111, 16'h2222, 16'h0000, 1'b1});
`ifndef EX_DIV_EN
    vecs.push_back('{ALU_DIV, 16'd100, 16'd7, 16'h0000, 1'b1});
`endif
    single_ops = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOT, ALU_SLL,
                   ALU_SRA, ALU_CMP, ALU_SLT, ALU_SW, ALU_LW, ALU_NOP};

    rst = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    aluOp_i = ALU_NOP; operand1_i = '0; operand2_i = '0; wReg_i = 1'b0; wRegAddr_i = '0;
    repeat (3) cycle();
    check("reset ready_o", ready_o, 0);
    check("reset control", {valid_o, busy_o, rMem_o, wMem_o, wReg_o}, 0);
    check("reset data", {wData_o, memAddr_o, wRegAddr_o, aluOp_o}, {16'h0, 16'h0, 3'd0, ALU_NOP});
    rst = 1'b0;
    cycle();
    check("idle ready_o", ready_o, 1);

    // Table vectors, back to back at one per cycle.
    ready_i = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      aluOp_i = vecs[i].op; operand1_i = vecs[i].a; operand2_i = vecs[i].b;
      wReg_i = i[0]; wRegAddr_i = i[2:0]; valid_i = 1'b1;
      #1;
      check($sformatf("vec%0d ready_o", i), ready_o, 1);
      cycle();
      check_single($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_d, vecs[i].chk_d);
      check($sformatf("vec%0d wreg", i), {wReg_o, wRegAddr_o}, {i[0], i[2:0]});
    end
    valid_i = 1'b0;
    cycle();
    check("drain after table", valid_o, 0);

    // MEM stall keeps the output register stable and blocks acceptance.
    ready_i = 1'b0;
    aluOp_i = ALU_ADD; operand1_i = 16'h0001; operand2_i = 16'h0002; valid_i = 1'b1;
    cycle();
    check("stall load valid", valid_o, 1);
    aluOp_i = ALU_SUB; operand1_i = 16'h0010; operand2_i = 16'h0001;
    bad = 1'b0;
    repeat (4) begin
      if (ready_o) bad = 1'b1;
      cycle();
      if (!valid_o || wData_o !== 16'h0003 || aluOp_o !== ALU_ADD) bad = 1'b1;
    end
    check("stall holds output", bad, 0);
    ready_i = 1'b1;
    #1;
    check("stall release ready_o", ready_o, 1);
    cycle();
    check("load+drain valid", valid_o, 1);
    check("load+drain data", wData_o, 16'h000F);
    valid_i = 1'b0;
    cycle();
    check("stall drained", valid_o, 0);

    // Iterative ops.
    run_iter("mul", ALU_MUL, 16'h0123, 16'h0010, 16'h1230, 1'b0);
    run_iter("mul stalled", ALU_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b1);
`ifdef EX_DIV_EN
    run_iter("div", ALU_DIV, 16'd100, 16'd7, 16'd14, 1'b0);
    run_iter("div by zero", ALU_DIV, 16'd5, 16'd0, 16'hFFFF, 1'b0);
    op = ALU_DIV;
`else
    op = ALU_MUL;
`endif

    // Flush in the middle of an iterative op.
    aluOp_i = op; operand1_i = 16'd1000; operand2_i = 16'd3; valid_i = 1'b1;
    cycle();
    valid_i = 1'b0;
    repeat (5) cycle();
    flush_i = 1'b1; valid_i = 1'b1; aluOp_i = ALU_ADD;
    #1;
    check("flush blocks ready_o", ready_o, 0);
    cycle();
    flush_i = 1'b0; valid_i = 1'b0;
    #1;
    check("after flush ready_o", ready_o, 1);
    check("after flush busy_o", busy_o, 0);
    bad = 1'b0;
    repeat (20) begin
      if (valid_o) bad = 1'b1;
      cycle();
    end
    check("flush suppresses result", bad, 0);

    // Reset in the middle of an iterative op.
    aluOp_i = ALU_MUL; operand1_i = 16'd7; operand2_i = 16'd9; valid_i = 1'b1;
    cycle();
    valid_i = 1'b0;
    repeat (4) cycle();
    rst = 1'b1;
    cycle();
    check("mid-iter reset", {valid_o, busy_o, ready_o}, 0);
    rst = 1'b0;
    bad = 1'b0;
    repeat (20) begin
      cycle();
      if (valid_o) bad = 1'b1;
    end
    check("reset discards op", bad, 0);
    check("ready after reset", ready_o, 1);

    // Random single-cycle ops, back to back.
    ready_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      op = single_ops[$urandom_range(0, 11)];
      a = 16'($urandom); b = 16'($urandom);
      aluOp_i = op; operand1_i = a; operand2_i = b; valid_i = 1'b1;
      cycle();
      check_single($sformatf("rnd%0d", i), op, a, b, ref_data(op, a, b), op != ALU_LW);
    end
    valid_i = 1'b0;
    cycle();

    // Random iterative ops.
    for (int i = 0; i < 8; i++) begin
`ifdef EX_DIV_EN
      op = i[0] ? ALU_DIV : ALU_MUL;
`else
      op = ALU_MUL;
`endif
      a = 16'($urandom);
      b = i[1] ? 16'($urandom_range(0, 300)) : 16'($urandom);
      run_iter($sformatf("rnditer%0d", i), op, a, b, ref_data(op, a, b), i[2]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
